// File: rtl/othello_io_bridge.sv
// othello_io_bridge
// Data-side companion of the single-cycle CPU. It holds the I/O registers
// (keyboard FIFO, status, LEDs, millisecond timer), buffers CPU VRAM writes
// until scanout blanking, and muxes RAM/VRAM/I/O read data back to the CPU.
// Ports:
//   clk, clrn                   clock, async active-low reset
//   m_addr, d_t_mem             CPU address / write data
//   io_rdn, io_wrn              active-low I/O read / write strobes
//   rvram, wvram                CPU VRAM read / write
//   ram_rdata, vram_rdata       read data from data RAM / VRAM
//   d_f_mem                     combinational read data to CPU
//   key_valid, key_code         PS/2 scancode strobe and value
//   vga_blank                   scanout is not reading VRAM
//   vram_raddr                  combinational VRAM read address
//   vram_we/waddr/wdata         registered VRAM write port
//   led                         LED register
module othello_io_bridge #(
  parameter int unsigned KEY_DEPTH  = 8,
  parameter int unsigned VBUF_DEPTH = 4,
  parameter int unsigned VRAM_AW    = 13,
  parameter int unsigned TICK_DIV   = 50000
) (
  input  logic               clk,
  input  logic               clrn,
  input  logic [31:0]        m_addr,
  input  logic [31:0]        d_t_mem,
  input  logic               io_rdn,
  input  logic               io_wrn,
  input  logic               rvram,
  input  logic               wvram,
  input  logic [31:0]        ram_rdata,
  output logic [31:0]        d_f_mem,
  input  logic               key_valid,
  input  logic [7:0]         key_code,
  input  logic               vga_blank,
  input  logic [31:0]        vram_rdata,
  output logic [VRAM_AW-1:0] vram_raddr,
  output logic               vram_we,
  output logic [VRAM_AW-1:0] vram_waddr,
  output logic [31:0]        vram_wdata,
  output logic [15:0]        led
);

  localparam int unsigned KAW = $clog2(KEY_DEPTH);
  localparam int unsigned KCW = KAW + 1;
  localparam int unsigned VAW = $clog2(VBUF_DEPTH);
  localparam int unsigned VCW = VAW + 1;
  localparam int unsigned PW  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned VEW = VRAM_AW + 32;

  localparam logic [KCW-1:0] KEY_FULL  = KCW'(KEY_DEPTH);
  localparam logic [VCW-1:0] VBUF_FULL = VCW'(VBUF_DEPTH);
  localparam logic [PW-1:0]  PRESC_MAX = PW'(TICK_DIV - 1);

  typedef enum logic [2:0] {
    IO_KEY    = 3'd0,
    IO_STATUS = 3'd1,
    IO_LED    = 3'd2,
    IO_TIMER  = 3'd3
  } io_sel_e;

  io_sel_e sel;
  assign sel        = io_sel_e'(m_addr[4:2]);
  assign vram_raddr = m_addr[VRAM_AW+1:2];

  logic unused_addr;
  assign unused_addr = ^{m_addr[31:VRAM_AW+2], m_addr[1:0]};

  logic io_rd, io_wr;
  assign io_rd = !io_rdn;
  assign io_wr = !io_wrn;

  // ---------------- keyboard FIFO ----------------
  logic [7:0]     key_mem [KEY_DEPTH];
  logic [KAW-1:0] key_wptr, key_rptr;
  logic [KCW-1:0] key_count;
  logic           key_ovf;
  logic           key_empty, key_full, key_pop, key_push, key_drop;

  assign key_empty = (key_count == '0);
  assign key_full  = (key_count == KEY_FULL);
  assign key_pop   = io_rd && (sel == IO_KEY) && !key_empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO
  // is still accepted; the written slot is the one being popped.
  assign key_push  = key_valid && (!key_full || key_pop);
  assign key_drop  = key_valid && key_full && !key_pop;

  always_ff @(posedge clk) begin
    if (key_push) key_mem[key_wptr] <= key_code;
  end

  // ---------------- VRAM write buffer ----------------
  logic [VEW-1:0] vbuf_mem [VBUF_DEPTH];
  logic [VAW-1:0] vbuf_wptr, vbuf_rptr;
  logic [VCW-1:0] vbuf_count;
  logic           vbuf_ovf;
  logic           vbuf_empty, vbuf_full, vbuf_drain, vbuf_push, vbuf_drop;

  assign vbuf_empty = (vbuf_count == '0);
  assign vbuf_full  = (vbuf_count == VBUF_FULL);
  assign vbuf_drain = vga_blank && !vbuf_empty;
  assign vbuf_push  = wvram && (!vbuf_full || vbuf_drain);
  assign vbuf_drop  = wvram && vbuf_full && !vbuf_drain;

  always_ff @(posedge clk) begin
    if (vbuf_push) vbuf_mem[vbuf_wptr] <= {m_addr[VRAM_AW+1:2], d_t_mem};
  end

  logic status_wr, led_wr, timer_wr;
  assign status_wr = io_wr && (sel == IO_STATUS);
  assign led_wr    = io_wr && (sel == IO_LED);
  assign timer_wr  = io_wr && (sel == IO_TIMER);

  logic [PW-1:0] presc;
  logic [31:0]   ms_count;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      key_wptr   <= '0;
      key_rptr   <= '0;
      key_count  <= '0;
      key_ovf    <= 1'b0;
      vbuf_wptr  <= '0;
      vbuf_rptr  <= '0;
      vbuf_count <= '0;
      vbuf_ovf   <= 1'b0;
      vram_we    <= 1'b0;
      vram_waddr <= '0;
      vram_wdata <= '0;
      led        <= '0;
      presc      <= '0;
      ms_count   <= '0;
    end else begin
      if (key_push) key_wptr <= key_wptr + KAW'(1);
      if (key_pop)  key_rptr <= key_rptr + KAW'(1);
      case ({key_push, key_pop})
        2'b10:   key_count <= key_count + KCW'(1);
        2'b01:   key_count <= key_count - KCW'(1);
        default: key_count <= key_count;
      endcase

      if (vbuf_push)  vbuf_wptr <= vbuf_wptr + VAW'(1);
      if (vbuf_drain) vbuf_rptr <= vbuf_rptr + VAW'(1);
      case ({vbuf_push, vbuf_drain})
        2'b10:   vbuf_count <= vbuf_count + VCW'(1);
        2'b01:   vbuf_count <= vbuf_count - VCW'(1);
        default: vbuf_count <= vbuf_count;
      endcase

      vram_we <= vbuf_drain;
      if (vbuf_drain) {vram_waddr, vram_wdata} <= vbuf_mem[vbuf_rptr];

      // A fresh overflow in the clearing cycle wins so it is never lost.
      if (status_wr) begin
        key_ovf  <= 1'b0;
        vbuf_ovf <= 1'b0;
      end
      if (key_drop)  key_ovf  <= 1'b1;
      if (vbuf_drop) vbuf_ovf <= 1'b1;

      if (led_wr) led <= d_t_mem[15:0];

      if (timer_wr) begin
        ms_count <= d_t_mem;
        presc    <= '0;
      end else if (presc == PRESC_MAX) begin
        ms_count <= ms_count + 32'd1;
        presc    <= '0;
      end else begin
        presc <= presc + PW'(1);
      end
    end
  end

  // ---------------- read mux ----------------
  logic [31:0] io_rdata;
  always_comb begin
    io_rdata = '0;
    case (sel)
      IO_KEY:    io_rdata = key_empty ? '0 : {23'b0, 1'b1, key_mem[key_rptr]};
      IO_STATUS: io_rdata = {16'b0, 8'(vbuf_count), 5'(key_count),
                             key_ovf, vbuf_ovf, vbuf_empty};
      IO_LED:    io_rdata = {16'b0, led};
      IO_TIMER:  io_rdata = ms_count;
      default:   io_rdata = '0;
    endcase
  end

  always_comb begin
    d_f_mem = ram_rdata;
    if (rvram)      d_f_mem = vram_rdata;
    else if (io_rd) d_f_mem = io_rdata;
  end

endmodule

// File: doc/othello_io_bridge.md
# othello_io_bridge

Downstream companion of the single-cycle CPU: consumes its data-side bus (m_addr, d_t_mem, write, io_rdn, io_wrn, rvram, wvram) and returns d_f_mem. It holds the I/O register file (keyboard FIFO, status, LEDs, millisecond timer) and a posted-write buffer that defers CPU VRAM writes until the VGA scanout is blanking. It also multiplexes data-RAM, VRAM and I/O read data onto one CPU read bus.

## Interface
- KEY_DEPTH, 8, keyboard FIFO entries (power of 2)
- VBUF_DEPTH, 4, VRAM write-buffer entries (power of 2)
- VRAM_AW, 13, VRAM word-address width
- TICK_DIV, 50000, clk cycles per timer tick
- clk  in  1  system clock, all state on rising edge
- clrn  in  1  asynchronous active-low reset
- m_addr  in  32  CPU byte address; word index = m_addr[VRAM_AW+1:2], I/O register select = m_addr[4:2]
- d_t_mem  in  32  CPU write data
- io_rdn  in  1  active-low I/O read strobe
- io_wrn  in  1  active-low I/O write strobe
- rvram  in  1  CPU VRAM read
- wvram  in  1  CPU VRAM write
- ram_rdata  in  32  data-RAM read data
- d_f_mem  out  32  read data to CPU (combinational)
- key_valid  in  1  one-cycle strobe from PS/2 decoder
- key_code  in  8  scancode qualified by key_valid
- vga_blank  in  1  high while scanout does not read VRAM
- vram_rdata  in  32  VRAM read-port data
- vram_raddr  out  VRAM_AW  VRAM read address = m_addr[VRAM_AW+1:2] (combinational)
- vram_we  out  1  registered VRAM write enable
- vram_waddr  out  VRAM_AW  registered VRAM write address
- vram_wdata  out  32  registered VRAM write data
- led  out  16  LED register

## Operation
- I/O map on m_addr[4:2]: 0 KEY_DATA, 1 STATUS, 2 LED, 3 TIMER; 4-7 read 0, writes ignored.
- d_f_mem priority: rvram -> vram_rdata; else io_rdn=0 -> selected I/O value; else ram_rdata.
- KEY_DATA read: {23'b0, !empty, head_code}; 0 when empty. The FIFO pops at the clock edge ending any cycle with io_rdn=0, select=0 and the FIFO not empty.
- Key push: on key_valid. Push and pop in the same cycle both take effect, including when full, so the count is unchanged.
- Key push when full with no pop: the code is dropped and key_ovf sets (sticky).
- STATUS read: {16'b0, vbuf_count[7:0], key_count[4:0], key_ovf, vbuf_ovf, vbuf_empty}. Any write to STATUS clears both sticky flags.
- LED write: led <= d_t_mem[15:0]. Read returns {16'b0, led}.
- TIMER: the prescaler counts 0..TICK_DIV-1. On wrap, ms_count increments and wraps at 2^32. A write loads ms_count <= d_t_mem and zeroes the prescaler. Read returns ms_count.
- VRAM write buffer:
  - An edge with wvram=1 enqueues {m_addr[VRAM_AW+1:2], d_t_mem}.
  - Enqueue when full and not draining this cycle: the entry is dropped and vbuf_ovf sets.
  - Enqueue while the buffer is full and draining is accepted.
- Drain: at each edge with vga_blank=1 and the buffer not empty, the head is registered into vram_waddr/vram_wdata, vram_we=1 for that one cycle, and the head pops. Otherwise vram_we=0. Maximum rate is one write per cycle, in FIFO order.
- No read-after-write forwarding. Software polls vbuf_empty before VRAM reads of freshly written locations.
- The write and io_wrn-for-RAM paths are not touched by this block; RAM is driven directly by the CPU.

## Timing
- Reset values (async, clrn=0): both FIFOs empty, pointers 0; key_ovf=vbuf_ovf=0; led=0; ms_count=0; prescaler=0; vram_we=0; vram_waddr=0; vram_wdata=0.
- d_f_mem, vram_raddr: zero-latency combinational, valid within the same CPU cycle.
- Register writes take effect at the edge ending the strobe cycle and are visible to a read in the next cycle.
- A key pushed at edge N is readable in cycle N+1.
- VRAM write latency: minimum one edge. A write enqueued at edge N with vga_blank=1 appears as vram_we=1 after edge N+1.
- Reset asserted mid-drain: pending entries are discarded and vram_we is forced low immediately.

## Test plan
- Reset with clrn=0: led=0, STATUS reads 0x0000_0001, vram_we=0 -> after release, TIMER reads 1 after exactly TICK_DIV clocks (use TICK_DIV=4 in the bench).
- Push keys 0x1C, 0x32, then read KEY_DATA twice, then once more -> 0x11C, 0x132, then 0x000; key_count returns to 0.
- Push 9 keys with no reads (KEY_DEPTH=8) -> STATUS key_count=8, key_ovf=1; STATUS write -> key_ovf=0, count stays 8. Simultaneous push+pop when full -> count stays 8, order preserved.
- vga_blank=0, three wvram writes to word addresses 0x10, 0x11, 0x12 (data 0xA,0xB,0xC) -> no vram_we, vbuf_count=3. Raise vga_blank -> three consecutive vram_we pulses in that order, then vbuf_empty=1.
- With vga_blank=0, five VRAM writes -> vbuf_ovf=1, only the first four are drained.
- LED write 0x0000_BEEF via io_wrn -> led=0xBEEF. TIMER write 0xFFFF_FFFF, then one tick -> reads 0x0000_0000. rvram read -> d_f_mem=vram_rdata, and ram_rdata is passed through when no strobe is active.
